// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline <-> CP0 exception controller bundle: MTC0/MFC0 access, MEM exception info,
// interrupt lines, and the flush/redirect response with the architectural register views.
interface cp0_exc_ctrl_if;
  logic        inst_valid;
  logic        cp0_write_en;
  logic        cp0_read_en;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_write_data;
  logic [31:0] cp0_read_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  modport master (
    output inst_valid, cp0_write_en, cp0_read_en, cp0_addr, cp0_write_data,
    output exc_valid, exc_code, exc_pc, exc_in_delay, exc_badvaddr, eret, hw_int,
    input  cp0_read_data, flush, redirect_valid, redirect_pc, status_o, cause_o, epc_o
  );

  modport slave (
    input  inst_valid, cp0_write_en, cp0_read_en, cp0_addr, cp0_write_data,
    input  exc_valid, exc_code, exc_pc, exc_in_delay, exc_badvaddr, eret, hw_int,
    output cp0_read_data, flush, redirect_valid, redirect_pc, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception/ERET/interrupt sequencer for the 5-stage core.
// Optional Count/Compare timer interrupt is enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  cp0_exc_ctrl_if.slave bus
);
  localparam logic [7:0]  ADDR_BADVADDR = 8'h40;
  localparam logic [7:0]  ADDR_COUNT    = 8'h48;
  localparam logic [7:0]  ADDR_COMPARE  = 8'h58;
  localparam logic [7:0]  ADDR_STATUS   = 8'h60;
  localparam logic [7:0]  ADDR_CAUSE    = 8'h68;
  localparam logic [7:0]  ADDR_EPC      = 8'h70;
  localparam logic [31:0] STATUS_RST    = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK   = 32'h0000_0300;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        idle_ok, int_pend;
  logic        take_int, take_exc, take_eret, take_mtc0;
  logic [4:0]  code_eff;
  logic        ti;
  logic [31:0] count_rd, compare_rd;
  logic [31:0] read_data;

  // Events are only honoured in IDLE; priority int > exception > ERET > MTC0.
  assign idle_ok   = (state_q == S_IDLE) && bus.inst_valid;
  assign int_pend  = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
  assign take_int  = idle_ok && int_pend;
  assign take_exc  = idle_ok && !int_pend && bus.exc_valid;
  assign take_eret = idle_ok && !int_pend && !bus.exc_valid && bus.eret;
  assign take_mtc0 = idle_ok && !int_pend && !bus.exc_valid && !bus.eret && bus.cp0_write_en;
  assign code_eff  = take_int ? 5'h00 : bus.exc_code;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        ti_q, ti_d, tick_q, tick_d;
  logic        wr_count, wr_compare;

  assign wr_count   = take_mtc0 && (bus.cp0_addr == ADDR_COUNT);
  assign wr_compare = take_mtc0 && (bus.cp0_addr == ADDR_COMPARE);

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count) begin
      count_d = bus.cp0_write_data;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end
    if (wr_compare) begin
      compare_d = bus.cp0_write_data;
    end
    // A Compare write acknowledges the timer and wins over a match in the same cycle.
    if (wr_compare) begin
      ti_d = 1'b0;
    end else if (tick_q && !wr_count && (compare_q != 32'd0) && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      tick_q    <= tick_d;
    end
  end

  assign ti         = ti_d;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    status_d         = status_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    badvaddr_d       = badvaddr_q;

    if (take_mtc0) begin
      case (bus.cp0_addr)
        ADDR_STATUS: status_d = (status_q & ~STATUS_WMASK) | (bus.cp0_write_data & STATUS_WMASK);
        ADDR_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (bus.cp0_write_data & CAUSE_WMASK);
        ADDR_EPC:    epc_d    = bus.cp0_write_data;
        default:     ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (take_int || take_exc) begin
          state_d          = S_FLUSH;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = EXC_VECTOR;
          // Nested entry keeps the original return point.
          if (!status_q[1]) begin
            epc_d       = bus.exc_in_delay ? (bus.exc_pc - 32'd4) : bus.exc_pc;
            cause_d[31] = bus.exc_in_delay;
          end
          cause_d[6:2] = code_eff;
          if (take_exc && ((bus.exc_code == 5'h04) || (bus.exc_code == 5'h05))) begin
            badvaddr_d = bus.exc_badvaddr;
          end
          status_d[1] = 1'b1;
        end else if (take_eret) begin
          state_d          = S_FLUSH;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = epc_q;
          status_d[1]      = 1'b0;
        end
      end
      S_FLUSH: begin
        state_d     = S_DRAIN;
        drain_cnt_d = 3'(DRAIN_CYCLES);
      end
      S_DRAIN: begin
        if (drain_cnt_q <= 3'd1) begin
          state_d     = S_IDLE;
          drain_cnt_d = 3'd0;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Hardware pending bits track the lines every cycle; IP7 also carries the timer.
    cause_d[15:10] = {bus.hw_int[5] | ti, bus.hw_int[4:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      drain_cnt_q      <= 3'd0;
      status_q         <= STATUS_RST;
      cause_q          <= 32'd0;
      epc_q            <= 32'd0;
      badvaddr_q       <= 32'd0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      status_q         <= status_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      badvaddr_q       <= badvaddr_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (bus.cp0_read_en) begin
      case (bus.cp0_addr)
        ADDR_BADVADDR: read_data = badvaddr_q;
        ADDR_COUNT:    read_data = count_rd;
        ADDR_COMPARE:  read_data = compare_rd;
        ADDR_STATUS:   read_data = status_q;
        ADDR_CAUSE:    read_data = cause_q;
        ADDR_EPC:      read_data = epc_q;
        default:       read_data = 32'd0;
      endcase
    end
  end

  assign bus.cp0_read_data  = read_data;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.status_o       = status_q;
  assign bus.cause_o        = cause_q;
  assign bus.epc_o          = epc_q;
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Owns the CP0 state: BadVAddr, Count, Compare, Status, Cause and EPC.
- Sequences exception entry, ERET return and timer/hardware interrupts for the 5-stage core.
- Consumes the decoded MTC0/MFC0 controls (write enable, read enable, 8-bit {rd,sel} address, write data) at MEM, plus exception info from MEM.
- Produces MFC0 read data, the pipeline flush and the redirect PC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry PC.
- DRAIN_CYCLES, 2, cycles after a flush during which exception/ERET/MTC0 inputs are ignored (range 1..7).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- inst_valid  input  1  MEM-stage instruction valid
- cp0_write_en  input  1  MTC0 at MEM
- cp0_read_en  input  1  MFC0 at MEM
- cp0_addr  input  8  {rd,sel}
- cp0_write_data  input  32  MTC0 data
- cp0_read_data  output  32  MFC0 data, combinational from current register state
- exc_valid  input  1  synchronous exception at MEM
- exc_code  input  5  ExcCode (AdEL 04, AdES 05, Sys 08, Bp 09, RI 0A, Ov 0C)
- exc_pc  input  32  PC of the MEM instruction
- exc_in_delay  input  1  MEM instruction is in a delay slot
- exc_badvaddr  input  32  faulting address, used for AdEL/AdES only
- eret  input  1  ERET at MEM
- hw_int  input  6  external interrupt lines, level-sensitive
- flush  output  1  squash IF..MEM
- redirect_valid  output  1  load redirect_pc into the PC
- redirect_pc  output  32  target PC
- status_o  output  32  Status
- cause_o  output  32  Cause
- epc_o  output  32  EPC

Behaviour:
Interface: one clock (clk); reset rst_n is asynchronous and active-low.

Reset values:
- Status = 32'h0040_0000 (BEV=1)
- Cause, EPC, BadVAddr, Count, Compare = 0
- flush = redirect_valid = 0, redirect_pc = 0
- FSM = IDLE, drain counter = 0

Register write masks:
- Status: only IM[15:8], EXL[1] and IE[0] are writable.
- Cause: only IP[9:8] (software interrupts) are writable.
- Cause.IP[15:10] = hw_int each cycle, except that IP[15] is ORed with the timer interrupt flag TI.
- Unmapped addresses read 0 and ignore writes.

Interrupt pending:
- int_pend = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Taken only when inst_valid=1, as ExcCode 00, with the priority below.

Event priority in IDLE with inst_valid=1: int_pend > exc_valid > eret > MTC0. The losing events in that cycle have no effect.

Exception/interrupt entry (registered, effective at the next clock edge):
- If Status.EXL was 0:
  - EPC = exc_in_delay ? exc_pc-4 : exc_pc
  - Cause.BD[31] = exc_in_delay
- If Status.EXL was 1, EPC and Cause.BD are left unchanged.
- Cause.ExcCode[6:2] = code.
- BadVAddr = exc_badvaddr, only for AdEL/AdES.
- Status.EXL = 1.
- Redirect target = EXC_VECTOR.

ERET:
- Status.EXL = 0.
- Redirect target = EPC value at the time ERET is accepted.

FSM:
- IDLE: on an accepted exception, interrupt or ERET, go to FLUSH.
- FLUSH (1 cycle):
  - flush = 1, redirect_valid = 1, redirect_pc registered at acceptance.
  - Next state DRAIN; drain counter loaded with DRAIN_CYCLES.
- DRAIN:
  - exc_valid, eret and cp0_write_en are ignored; interrupts are not taken.
  - Counter decrements; go to IDLE when it reaches 1.
- Latency: event at MEM in cycle N gives flush/redirect in cycle N+1 and the first IDLE cycle at N+2+DRAIN_CYCLES.

MTC0 vs. reads:
- MTC0 takes effect at the clock edge.
- An MFC0 in the same cycle to the same address returns the old value; no forwarding.

Reset mid-operation: rst_n low in any state returns all state to reset values immediately (asynchronous).

Optional Feature:
Macro CP0_TIMER_EN.

Defined:
- Count increments every second clk cycle via an internal toggle bit that resets to 0.
- Count and Compare are R/W.
- When Count == Compare (after the increment) and Compare != 0, TI is set.
- An MTC0 to Compare clears TI and takes priority over a set in the same cycle.
- An MTC0 to Count overrides the increment.

Undefined:
- Count and Compare read 0 and ignore writes.
- TI is constant 0, so Cause.IP[15] follows hw_int[5] only.

Test Plan:
1. Reset released, MFC0 address {12,0} -> cp0_read_data = 32'h0040_0000; flush = 0.
2. exc_valid, code 0C, exc_pc = 32'h8000_1000, not in delay slot -> next cycle flush = 1, redirect_pc = 32'hBFC00380; EPC = 32'h8000_1000, Cause[6:2] = 0C, Status.EXL = 1; exc_valid during the following 2 cycles is ignored.
3. Same exception with exc_in_delay = 1 and exc_pc = 32'h8000_1004 -> EPC = 32'h8000_1000, Cause[31] = 1; then ERET -> redirect_pc = 32'h8000_1000, Status.EXL = 0.
4. MTC0 Status = 32'h0000_0401 with hw_int[0] = 1 and inst_valid = 1 -> interrupt taken the next cycle, ExcCode 00; a simultaneous exc_valid (code 0A) is dropped.
5. CP0_TIMER_EN defined, MTC0 Compare = 5, MTC0 Count = 0 -> TI set after 10 cycles, Cause[15] = 1; MTC0 Compare = 5 -> Cause[15] = 0.
6. Assert rst_n low while in DRAIN -> flush = 0 and Status = 32'h0040_0000 immediately; the FSM is in IDLE after release.
